// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared pipeline types, ALU encodings and forwarding helper
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int SHAMT_W    = $clog2(XLEN);

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_PASSB = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0]       pc_address;
    logic [XLEN-1:0]       reg_read_data1;
    logic [XLEN-1:0]       reg_read_data2;
    logic [XLEN-1:0]       imm;
    logic [3:0]            funct_inst_bits;
    logic [REG_ADDR_W-1:0] rd;
  } id_ex_data_t;

  typedef struct packed {
    logic       WB_reg_write;
    logic       WB_mem_to_reg;
    logic       M_branch;
    logic       M_mem_read;
    logic       M_mem_write;
    logic [1:0] EX_ALU_Op;
    logic       EX_ALU_Src;
  } id_ex_control_t;

  typedef struct packed {
    logic [XLEN-1:0]       branch_target;
    logic                  zero;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       write_data;
    logic [REG_ADDR_W-1:0] rd;
  } ex_mem_data_t;

  typedef struct packed {
    logic WB_reg_write;
    logic WB_mem_to_reg;
    logic M_branch;
    logic M_mem_read;
    logic M_mem_write;
  } ex_mem_control_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // Loads sitting in EX/MEM have no data yet, so they are excluded here.
  function automatic fwd_sel_e fwd_select(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  exmem_wen,
    input logic                  exmem_is_load,
    input logic [REG_ADDR_W-1:0] exmem_rd,
    input logic                  memwb_wen,
    input logic [REG_ADDR_W-1:0] memwb_rd
  );
    if (exmem_wen && !exmem_is_load && (exmem_rd != '0) && (exmem_rd == rs))
      return FWD_EXMEM;
    else if (memwb_wen && (memwb_rd != '0) && (memwb_rd == rs))
      return FWD_MEMWB;
    else
      return FWD_REG;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_alu.sv
// ============================================================================
// ex_alu : combinational integer ALU for the execute stage
// Rev 1.0
// ============================================================================
`default_nettype none

module ex_alu
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_op_e         op_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = b_i[SHAMT_W-1:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_SLL:   result_o = a_i << shamt;
      ALU_SLT:   result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU:  result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_SRL:   result_o = a_i >> shamt;
      ALU_SRA:   result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:    result_o = a_i | b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_PASSB: result_o = b_i;
      default:   result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// ex_stage : operand forwarding, ALU control, ALU/branch target, EX/MEM register
// Rev 1.0
// ============================================================================
`default_nettype none

module ex_stage
  import cpu_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  id_ex_data_t           data_in,
  input  id_ex_control_t        control_in,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  mem_wb_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic [XLEN-1:0]       mem_wb_result,
  input  logic                  stall,
  input  logic                  flush,
  output ex_mem_data_t          data_out,
  output ex_mem_control_t       control_out
);

  ex_mem_data_t    data_q, data_d;
  ex_mem_control_t ctrl_q, ctrl_d;

  fwd_sel_e        fwd_a, fwd_b;
  logic [XLEN-1:0] op_a, rs2_val, op_b;
  logic [3:0]      funct_eff;
  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  // Forwarding always looks at the registered EX/MEM contents, held or not.
  assign fwd_a = fwd_select(rs1, ctrl_q.WB_reg_write, ctrl_q.WB_mem_to_reg, data_q.rd,
                            mem_wb_reg_write, mem_wb_rd);
  assign fwd_b = fwd_select(rs2, ctrl_q.WB_reg_write, ctrl_q.WB_mem_to_reg, data_q.rd,
                            mem_wb_reg_write, mem_wb_rd);

  always_comb begin
    op_a = data_in.reg_read_data1;
    case (fwd_a)
      FWD_EXMEM: op_a = data_q.alu_result;
      FWD_MEMWB: op_a = mem_wb_result;
      default:   op_a = data_in.reg_read_data1;
    endcase
  end

  always_comb begin
    rs2_val = data_in.reg_read_data2;
    case (fwd_b)
      FWD_EXMEM: rs2_val = data_q.alu_result;
      FWD_MEMWB: rs2_val = mem_wb_result;
      default:   rs2_val = data_in.reg_read_data2;
    endcase
  end

  assign op_b = control_in.EX_ALU_Src ? data_in.imm : rs2_val;

  // Immediate forms carry no funct7 except srai, so bit 3 is masked for them.
  always_comb begin
    funct_eff = data_in.funct_inst_bits;
    if (control_in.EX_ALU_Src && (data_in.funct_inst_bits[2:0] != 3'b101))
      funct_eff[3] = 1'b0;
  end

  always_comb begin
    alu_op = ALU_ADD;
    case (control_in.EX_ALU_Op)
      ALU_OP_ADD:   alu_op = ALU_ADD;
      ALU_OP_SUB:   alu_op = ALU_SUB;
      ALU_OP_PASSB: alu_op = ALU_PASSB;
      ALU_OP_RTYPE: begin
        case (funct_eff)
          4'b0000: alu_op = ALU_ADD;
          4'b1000: alu_op = ALU_SUB;
          4'b0001: alu_op = ALU_SLL;
          4'b0010: alu_op = ALU_SLT;
          4'b0011: alu_op = ALU_SLTU;
          4'b0100: alu_op = ALU_XOR;
          4'b0101: alu_op = ALU_SRL;
          4'b1101: alu_op = ALU_SRA;
          4'b0110: alu_op = ALU_OR;
          4'b0111: alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

  ex_alu u_alu (
    .a_i      (op_a),
    .b_i      (op_b),
    .op_i     (alu_op),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (!stall) begin
      data_d.branch_target = data_in.pc_address + data_in.imm;
      data_d.zero          = alu_zero;
      data_d.alu_result    = alu_result;
      data_d.write_data    = rs2_val;
      data_d.rd            = data_in.rd;
      if (flush) begin
        ctrl_d = '0;
      end else begin
        ctrl_d.WB_reg_write  = control_in.WB_reg_write;
        ctrl_d.WB_mem_to_reg = control_in.WB_mem_to_reg;
        ctrl_d.M_branch      = control_in.M_branch;
        ctrl_d.M_mem_read    = control_in.M_mem_read;
        ctrl_d.M_mem_write   = control_in.M_mem_write;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign data_out    = data_q;
  assign control_out = ctrl_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// tb_ex_stage : directed vector bench for ex_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ex_stage;
  import cpu_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset;
  id_ex_data_t           data_in;
  id_ex_control_t        control_in;
  logic [REG_ADDR_W-1:0] rs1, rs2;
  logic                  mem_wb_reg_write;
  logic [REG_ADDR_W-1:0] mem_wb_rd;
  logic [XLEN-1:0]       mem_wb_result;
  logic                  stall, flush;
  ex_mem_data_t          data_out;
  ex_mem_control_t       control_out;

  int errors = 0;
  int checks = 0;

  ex_stage dut (
    .clock            (clock),
    .reset            (reset),
    .data_in          (data_in),
    .control_in       (control_in),
    .rs1              (rs1),
    .rs2              (rs2),
    .mem_wb_reg_write (mem_wb_reg_write),
    .mem_wb_rd        (mem_wb_rd),
    .mem_wb_result    (mem_wb_result),
    .stall            (stall),
    .flush            (flush),
    .data_out         (data_out),
    .control_out      (control_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  c5;
    logic [1:0]  op;
    logic        src;
    logic [3:0]  f;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [31:0] wbres;
    logic        st, fl;
    logic [31:0] e_alu;
    logic        e_zero;
    logic [31:0] e_bt, e_wd;
    logic [4:0]  e_rd, e_c5;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t V(
    input logic [4:0] c5, input logic [1:0] op, input logic src, input logic [3:0] f,
    input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
    input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
    input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbres,
    input logic st, input logic fl,
    input logic [31:0] e_alu, input logic e_zero, input logic [31:0] e_bt,
    input logic [31:0] e_wd, input logic [4:0] e_rd, input logic [4:0] e_c5);
    vec_t v;
    v.c5 = c5; v.op = op; v.src = src; v.f = f; v.pc = pc; v.d1 = d1; v.d2 = d2; v.imm = imm;
    v.rs1 = r1; v.rs2 = r2; v.rd = rd; v.wbw = wbw; v.wbrd = wbrd; v.wbres = wbres;
    v.st = st; v.fl = fl; v.e_alu = e_alu; v.e_zero = e_zero; v.e_bt = e_bt;
    v.e_wd = e_wd; v.e_rd = e_rd; v.e_c5 = e_c5;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    control_in                 = {v.c5, v.op, v.src};
    data_in.pc_address         = v.pc;
    data_in.reg_read_data1     = v.d1;
    data_in.reg_read_data2     = v.d2;
    data_in.imm                = v.imm;
    data_in.funct_inst_bits    = v.f;
    data_in.rd                 = v.rd;
    rs1                        = v.rs1;
    rs2                        = v.rs2;
    mem_wb_reg_write           = v.wbw;
    mem_wb_rd                  = v.wbrd;
    mem_wb_result              = v.wbres;
    stall                      = v.st;
    flush                      = v.fl;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  localparam logic [4:0] R  = 5'b10000;
  localparam logic [4:0] LD = 5'b11010;
  localparam logic [4:0] BR = 5'b00100;
  localparam logic [4:0] SW = 5'b00001;

  initial begin
    // {ctrl, op, src, f, pc, d1, d2, imm, rs1, rs2, rd, wbw, wbrd, wbres, stall, flush,
    //  exp alu, zero, branch_target, write_data, rd, ctrl}
    vecs.push_back(V(R, 2'b10, 0, 4'b0000, 0, 5, 7, 0, 1, 2, 3, 0, 0, 0, 0, 0, 12, 0, 0, 7, 3, R));
    vecs.push_back(V(R, 2'b10, 0, 4'b1000, 0, 0, 5, 0, 3, 1, 4, 0, 0, 0, 0, 0, 7, 0, 0, 5, 4, R));
    vecs.push_back(V(R, 2'b10, 0, 4'b0000, 0, 1, 2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 3, 0, 0, 2, 0, R));
    vecs.push_back(V(R, 2'b10, 0, 4'b1000, 0, 20, 5, 0, 0, 5, 4, 0, 0, 0, 0, 0, 15, 0, 0, 5, 4, R));
    vecs.push_back(V(R, 2'b10, 0, 4'b0000, 0, 5, 7, 0, 1, 2, 3, 0, 0, 0, 0, 0, 12, 0, 0, 7, 3, R));
    vecs.push_back(V(R, 2'b10, 0, 4'b0000, 0, 0, 0, 0, 3, 0, 5, 1, 3, 100, 0, 0, 12, 0, 0, 0, 5, R));
    vecs.push_back(V(R, 2'b10, 0, 4'b0000, 0, 0, 9, 0, 3, 3, 6, 1, 3, 100, 0, 0, 200, 0, 0, 100, 6, R));
    vecs.push_back(V(LD, 2'b00, 1, 4'b0000, 0, 32'h1000, 11, 4, 1, 2, 7, 0, 0, 0, 0, 0, 32'h1004, 0, 4, 11, 7, LD));
    vecs.push_back(V(R, 2'b10, 0, 4'b0000, 0, 1, 2, 0, 7, 7, 8, 0, 0, 0, 0, 0, 3, 0, 0, 2, 8, R));
    vecs.push_back(V(R, 2'b10, 0, 4'b1000, 0, 50, 0, 0, 1, 8, 9, 0, 0, 0, 0, 0, 47, 0, 0, 3, 9, R));
    vecs.push_back(V(R, 2'b10, 1, 4'b1000, 0, 1, 7, 32'hFFFF_FFFF, 1, 2, 10, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 7, 10, R));
    vecs.push_back(V(R, 2'b10, 1, 4'b1101, 0, 32'h8000_0000, 7, 4, 1, 2, 11, 0, 0, 0, 0, 0, 32'hF800_0000, 0, 4, 7, 11, R));
    vecs.push_back(V(BR, 2'b01, 0, 4'b0000, 32'hFFFF_FFFC, 5, 5, 8, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 4, 5, 0, BR));
    vecs.push_back(V(R, 2'b11, 1, 4'b0000, 0, 99, 7, 32'h1234_5000, 1, 2, 12, 0, 0, 0, 0, 0, 32'h1234_5000, 0, 32'h1234_5000, 7, 12, R));
    vecs.push_back(V(R, 2'b10, 0, 4'b0001, 0, 1, 32'h21, 0, 1, 2, 13, 0, 0, 0, 0, 0, 2, 0, 0, 32'h21, 13, R));
    vecs.push_back(V(R, 2'b10, 0, 4'b0010, 0, 32'hFFFF_FFFF, 1, 0, 1, 2, 14, 0, 0, 0, 0, 0, 1, 0, 0, 1, 14, R));
    vecs.push_back(V(R, 2'b10, 0, 4'b0011, 0, 32'hFFFF_FFFF, 1, 0, 1, 2, 15, 0, 0, 0, 0, 0, 0, 1, 0, 1, 15, R));
    vecs.push_back(V(R, 2'b10, 0, 4'b0100, 0, 32'hF0, 32'hFF, 0, 1, 2, 16, 0, 0, 0, 0, 0, 32'h0F, 0, 0, 32'hFF, 16, R));
    vecs.push_back(V(R, 2'b10, 0, 4'b0101, 0, 32'h8000_0000, 4, 0, 1, 2, 17, 0, 0, 0, 0, 0, 32'h0800_0000, 0, 0, 4, 17, R));
    vecs.push_back(V(R, 2'b10, 0, 4'b1101, 0, 32'h8000_0000, 4, 0, 1, 2, 18, 0, 0, 0, 0, 0, 32'hF800_0000, 0, 0, 4, 18, R));
    vecs.push_back(V(R, 2'b10, 0, 4'b0110, 0, 32'hF0, 32'h0F, 0, 1, 2, 19, 0, 0, 0, 0, 0, 32'hFF, 0, 0, 32'h0F, 19, R));
    vecs.push_back(V(R, 2'b10, 0, 4'b0111, 0, 32'hF0, 32'h3C, 0, 1, 2, 20, 0, 0, 0, 0, 0, 32'h30, 0, 0, 32'h3C, 20, R));
    // three stall cycles with changing inputs, then stall+flush: all hold
    for (int i = 0; i < 3; i++)
      vecs.push_back(V(R, 2'b10, 0, 4'b0000, 32'h40 + i, 9 + i, 9, 1, 20, 20, 21, 0, 0, 0, 1, 0, 32'h30, 0, 0, 32'h3C, 20, R));
    vecs.push_back(V(BR, 2'b01, 0, 4'b0000, 0, 1, 2, 3, 1, 2, 22, 0, 0, 0, 1, 1, 32'h30, 0, 0, 32'h3C, 20, R));
    // release: forwarding from the held EX/MEM entry
    vecs.push_back(V(R, 2'b10, 0, 4'b0000, 0, 0, 1, 0, 20, 2, 22, 0, 0, 0, 0, 0, 32'h31, 0, 0, 1, 22, R));
    vecs.push_back(V(R, 2'b10, 0, 4'b0000, 0, 2, 3, 0, 1, 2, 23, 0, 0, 0, 0, 1, 5, 0, 0, 3, 23, 5'b00000));
    vecs.push_back(V(R, 2'b10, 0, 4'b0000, 0, 4, 6, 0, 23, 2, 24, 0, 0, 0, 0, 0, 10, 0, 0, 6, 24, R));
    vecs.push_back(V(SW, 2'b00, 1, 4'b0000, 0, 32'h100, 32'h55, 32'hFFFF_FFFC, 1, 2, 5, 0, 0, 0, 0, 0, 32'hFC, 0, 32'hFFFF_FFFC, 32'h55, 5, SW));
    vecs.push_back(V(BR, 2'b01, 0, 4'b0000, 0, 0, 1, 0, 5, 2, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 1, 0, BR));

    // reset with nonzero inputs and flush/stall asserted
    reset = 1'b1;
    drive(vecs[6]);
    stall = 1'b1;
    flush = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("reset data_out", -1, 128'(data_out), '0);
    check("reset control_out", -1, 128'(control_out), '0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clock); #1;
      check("alu_result", i, 128'(data_out.alu_result), 128'(vecs[i].e_alu));
      check("zero", i, 128'(data_out.zero), 128'(vecs[i].e_zero));
      check("branch_target", i, 128'(data_out.branch_target), 128'(vecs[i].e_bt));
      check("write_data", i, 128'(data_out.write_data), 128'(vecs[i].e_wd));
      check("rd", i, 128'(data_out.rd), 128'(vecs[i].e_rd));
      check("control_out", i, 128'(control_out), 128'(vecs[i].e_c5));
    end

    // reset while a valid instruction is held by stall
    drive(vecs[0]);
    @(posedge clock); #1;
    check("pre-reset load", 100, 128'(data_out.alu_result), 128'(32'd12));
    stall = 1'b1;
    drive(vecs[1]);
    stall = 1'b1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("midop reset data_out", 101, 128'(data_out), '0);
    check("midop reset control_out", 101, 128'(control_out), '0);
    reset = 1'b0;
    stall = 1'b0;
    @(posedge clock); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
